// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: segment patterns,
// scan FSM states and digit-count constants.
package seven_seg_scanner_pkg;

  // Number of display digits and the width of the digit index.
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Segment patterns, ordered {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan controller states: BLANK until the first prescaler tick, then SCAN.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } scan_state_t;

  // BCD code to active-low segment pattern; non-decimal codes show nothing.
  function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
    logic [6:0] pat;
    unique case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder (active-low outputs) with a
// blank override used for leading-zero suppression.
module seven_seg_scanner_bcd_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blank overrides the decoded pattern; A-F decode to blank as well.
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      o_seg = seg_pattern(i_bcd);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode multiplexed display driver. Captures the BCD
// metric and distance flag once per scan frame so a frame is never torn.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic        clk100MHz,
  input  logic        reset_n,
  input  logic [15:0] digit_data,
  input  logic        distance_flag,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("seven_seg_scanner: CLK_HZ/REFRESH_HZ must be at least 2");
  end

  // Prescaler and scan state
  logic [CNT_W-1:0] r_count;
  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] w_index_next;
  logic             w_tick;
  logic             w_frame_tick;

  // Frame shadow of the input metric
  logic [15:0]      r_shadow_data;
  logic             r_shadow_flag;
  logic [15:0]      w_frame_data;
  logic             w_frame_flag;

  // Next displayed digit
  logic [3:0]       w_nibble;
  logic             w_d3_zero;
  logic             w_d2_zero;
  logic             w_d1_zero;
  logic             w_lz_blank;
  logic [6:0]       w_seg_next;
  logic [3:0]       w_an_next;
  logic             w_dp_next;

  // Registered outputs
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_start;

  // Prescaler: free-running 0..DIV-1, tick on the terminal count.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_tick = (r_count == CNT_LAST);

  // Scan FSM state and digit index registers.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BLANK;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  // Scan FSM next state: first tick leaves BLANK at digit 0, then walk 0..3.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    if (w_tick) begin
      unique case (r_state)
        ST_BLANK: begin
          w_state_next = ST_SCAN;
          w_index_next = '0;
        end
        ST_SCAN: begin
          w_index_next = (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);
        end
        default: begin
          w_state_next = ST_BLANK;
          w_index_next = '0;
        end
      endcase
    end
  end

  assign w_frame_tick = w_tick && (w_index_next == '0);

  // Frame shadow: reload from the inputs on the tick that starts a frame.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_data <= '0;
      r_shadow_flag <= 1'b0;
    end else if (w_frame_tick) begin
      r_shadow_data <= digit_data;
      r_shadow_flag <= distance_flag;
    end
  end

  // The first digit of a frame is decoded from the incoming values, since the
  // shadow only takes them on that same edge.
  assign w_frame_data = w_frame_tick ? digit_data    : r_shadow_data;
  assign w_frame_flag = w_frame_tick ? distance_flag : r_shadow_flag;

  // Digit selection, leading-zero suppression, decimal point and anode enable.
  always_comb begin
    w_nibble   = w_frame_data[{w_index_next, 2'b00} +: 4];
    w_d3_zero  = (w_frame_data[15:12] == 4'd0);
    w_d2_zero  = (w_frame_data[11:8]  == 4'd0);
    w_d1_zero  = (w_frame_data[7:4]   == 4'd0);
    w_lz_blank = 1'b0;
    unique case (w_index_next)
      2'd3:    w_lz_blank = w_d3_zero;
      2'd2:    w_lz_blank = w_d3_zero && w_d2_zero && !w_frame_flag;
      2'd1:    w_lz_blank = w_d3_zero && w_d2_zero && w_d1_zero && !w_frame_flag;
      default: w_lz_blank = 1'b0;
    endcase
    w_dp_next = !((w_index_next == 2'd2) && w_frame_flag);
    w_an_next = ~(4'b0001 << w_index_next);
  end

  seven_seg_scanner_bcd_to_seg u_bcd_to_seg (
    .i_bcd   (w_nibble),
    .i_blank (w_lz_blank),
    .o_seg   (w_seg_next)
  );

  // Display registers: load the new digit on each tick, hold otherwise.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  // Frame marker: one cycle, aligned with digit 0 appearing.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset_n;
  logic [15:0] digit_data;
  logic        distance_flag;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];

  seven_seg_scanner #(
    .CLK_HZ     (8),
    .REFRESH_HZ (2)
  ) dut (
    .clk100MHz     (clk),
    .reset_n       (reset_n),
    .digit_data    (digit_data),
    .distance_flag (distance_flag),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: ref_seg = 7'b1000000;
      4'd1: ref_seg = 7'b1111001;
      4'd2: ref_seg = 7'b0100100;
      4'd3: ref_seg = 7'b0110000;
      4'd4: ref_seg = 7'b0011001;
      4'd5: ref_seg = 7'b0010010;
      4'd6: ref_seg = 7'b0000010;
      4'd7: ref_seg = 7'b1111000;
      4'd8: ref_seg = 7'b0000000;
      4'd9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b1111111;
    endcase
  endfunction

  // Expected display for digit i of a frame built from (data, flag).
  function automatic exp_t model(input logic [15:0] data, input logic flag, input int unsigned i);
    exp_t e;
    logic [3:0] nib;
    bit lead_zero;
    nib = data[i*4 +: 4];
    lead_zero = 1'b1;
    for (int unsigned k = i; k < 4; k++)
      if (data[k*4 +: 4] != 4'd0) lead_zero = 1'b0;
    e.an = 4'b1111;
    e.an[i] = 1'b0;
    if (i != 0 && lead_zero && (i == 3 || !flag)) e.seg = 7'b1111111;
    else e.seg = ref_seg(nib);
    e.dp = !(i == 2 && flag);
    return e;
  endfunction

  // Step at least one negedge, then wait (bounded) for a frame_start sample.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; digit_data = 16'h0123; distance_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got an=%b seg=%b dp=%b fs=%b", an, seg, dp, frame_start);
    end
    q.push_back(model(16'h0123, 1'b0, 0));
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({an, seg, dp, frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_blank_cycle%0d got an=%b seg=%b dp=%b fs=%b", c, an, seg, dp, frame_start);
      end
      @(negedge clk);
    end
    e = q.pop_front();
    checks++;
    if ({an, seg, dp, frame_start} !== {e.an, e.seg, e.dp, 1'b1}) begin
      errors++;
      $display("FAIL first_digit got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=1",
               an, seg, dp, frame_start, e.an, e.seg, e.dp);
    end
    @(negedge clk);
    checks++;
    if ({an, frame_start} !== {4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL frame_start_pulse got an=%b fs=%b exp an=1110 fs=0", an, frame_start);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] tbl_d [3];
    logic        tbl_f [3];
    exp_t e;
    bit ok;
    tbl_d[0] = 16'h0123; tbl_f[0] = 1'b0;
    tbl_d[1] = 16'h0042; tbl_f[1] = 1'b1;
    tbl_d[2] = 16'h00AB; tbl_f[2] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      digit_data = tbl_d[p]; distance_flag = tbl_f[p];
      for (int unsigned d = 0; d < 4; d++) q.push_back(model(tbl_d[p], tbl_f[p], d));
      wait_frame(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pattern%0d_frame_timeout got none required frame_start", p);
        q.delete();
        continue;
      end
      for (int d = 0; d < 4; d++) begin
        e = q.pop_front();
        checks++;
        if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
          errors++;
          $display("FAIL pattern%0d_digit%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                   p, d, an, seg, dp, e.an, e.seg, e.dp);
        end
        repeat (4) @(negedge clk);
      end
      checks++;
      if (frame_start !== 1'b1) begin
        errors++;
        $display("FAIL pattern%0d_period got fs=%b exp fs=1 after 16 cycles", p, frame_start);
      end
    end
  endtask

  task automatic test_midframe_change();
    exp_t e;
    bit ok;
    digit_data = 16'h0123; distance_flag = 1'b0;
    for (int unsigned d = 0; d < 4; d++) q.push_back(model(16'h0123, 1'b0, d));
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midframe_timeout got none required frame_start");
      q.delete();
      return;
    end
    for (int d = 0; d < 4; d++) begin
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        errors++;
        $display("FAIL midframe_old_digit%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                 d, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (d == 1) begin
        digit_data = 16'h0456;
        for (int unsigned k = 0; k < 4; k++) q.push_back(model(16'h0456, 1'b0, k));
      end
      if (d < 3) repeat (4) @(negedge clk);
    end
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midframe_new_timeout got none required frame_start");
      q.delete();
      return;
    end
    for (int d = 0; d < 4; d++) begin
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        errors++;
        $display("FAIL midframe_new_digit%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                 d, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (d < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    digit_data = 16'h1234; distance_flag = 1'b0;
    for (int unsigned d = 0; d < 4; d++) q.push_back(model(16'h1234, 1'b0, d));
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout got none required frame_start");
      q.delete();
      return;
    end
    for (int d = 0; d < 4; d++) begin
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        errors++;
        $display("FAIL b2b_first_digit%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                 d, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (d < 3) repeat (4) @(negedge clk);
    end
    // Change data in the cycle whose closing edge is the frame-start tick.
    repeat (3) @(negedge clk);
    digit_data = 16'h9876; distance_flag = 1'b1;
    for (int unsigned d = 0; d < 4; d++) q.push_back(model(16'h9876, 1'b1, d));
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frame_start got fs=%b exp fs=1", frame_start);
    end
    for (int d = 0; d < 4; d++) begin
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        errors++;
        $display("FAIL b2b_tick_capture_digit%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                 d, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (d < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got an=%b seg=%b dp=%b fs=%b exp blank", an, seg, dp, frame_start);
    end
    @(negedge clk);
    q.push_back(model(16'h9876, 1'b1, 0));
    q.push_back(model(16'h9876, 1'b1, 1));
    reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({an, frame_start} !== {4'b1111, 1'b0}) begin
        errors++;
        $display("FAIL restart_blank_cycle%0d got an=%b fs=%b exp an=1111 fs=0", c, an, frame_start);
      end
    end
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if ({an, seg, dp, frame_start} !== {e.an, e.seg, e.dp, 1'b1}) begin
      errors++;
      $display("FAIL restart_digit0 got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=1",
               an, seg, dp, frame_start, e.an, e.seg, e.dp);
    end
    repeat (4) @(negedge clk);
    e = q.pop_front();
    checks++;
    if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
      errors++;
      $display("FAIL restart_digit1 got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
               an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    digit_data = '0;
    distance_flag = 1'b0;
    test_reset();
    test_patterns();
    test_midframe_change();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Display-side consumer of the fitness metric cycler: takes the currently selected metric as four BCD digits plus the distance flag and drives a 4-digit, common-anode, time-multiplexed seven-segment display. Input data is captured once per scan frame so a metric switch never produces a torn frame. The block sits between the metric cycler and the board display pins, clocked from the 100 MHz board clock.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- REFRESH_HZ, 1000, digit-advance rate in Hz; DIV = CLK_HZ/REFRESH_HZ, DIV >= 2 (elaboration error otherwise)
- clk100MHz  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- digit_data  in  16  four BCD digits; [15:12]=digit 3 (leftmost) … [3:0]=digit 0 (rightmost)
- distance_flag  in  1  1 = distance metric; show decimal point after digit 2 (format DD.DD)
- an  out  4  digit enables, active low, one-hot-low while scanning; an[i] drives digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- frame_start  out  1  one-cycle pulse, high while digit 0 is first shown in a new frame

## Operation
- Prescaler counts 0..DIV-1; tick = cycle where count == DIV-1; count wraps to 0.
- FSM: BLANK (after reset), SCAN. BLANK -> SCAN on first tick; SCAN stays until reset.
- Digit index 0..3; on tick: BLANK->index 0; SCAN: 3 wraps to 0, else +1.
- On tick where new index is 0: shadow_data <= digit_data, shadow_flag <= distance_flag; displayed outputs for that digit use the incoming values (bypass), not the stale shadow.
- Decode: 0–9 standard patterns (e.g. 0=1000000, 3=0110000, 4=0011001); codes A–F -> blank (1111111).
- dp = 0 only when index==2 and flag==1; else 1.
- Leading-zero blanking: digit 3 blank if zero; digit 2 blank if zero and digit 3 zero and flag==0; digit 1 blank if digits 3..1 all zero and flag==0; digit 0 never blanked. With flag==1, digits 2..0 never blanked. Blanked digit: seg=1111111, an still asserted.
- frame_start high for the one cycle following a tick that selected index 0.

## Timing
- Reset values (asynchronous, immediate): an=1111, seg=1111111, dp=1, frame_start=0, count=0, index=0, shadow=0, state BLANK.
- an/seg/dp are registered; all update in the cycle after a tick (1-cycle latency from tick), constant for DIV cycles.
- First digit appears DIV cycles after reset release (tick at count DIV-1, outputs valid next edge).
- Frame period = 4·DIV cycles; data change mid-frame invisible until next frame_start.
- Input change in the exact tick cycle that starts a frame is captured.
- Reset mid-scan: outputs go blank asynchronously; restart from BLANK, no partial frame resumes.

## Structure
- Shared package: segment pattern constants for 0–9 and SEG_BLANK, state encoding (BLANK, SCAN), digit count constant 4.
- One natural sub-module: bcd_to_seg (combinational 4-bit -> 7-bit active-low decoder with blank input); prescaler, FSM, shadow and blanking logic stay in the top.

## Test plan
All with CLK_HZ=8, REFRESH_HZ=2 (DIV=4).
- Reset held, then released -> an=1111, seg=1111111, dp=1 for cycles 1–4; on cycle 5 an=1110, frame_start=1 for that cycle only.
- digit_data=16'h0123, flag=0 -> sequence an=1110 seg=0110000 (3), 1101 seg=0100100 (2), 1011 seg=1111001 (1), 0111 seg=1111111 (blanked 0); dp=1 throughout; repeats every 16 cycles.
- digit_data=16'h0042, flag=1 -> digits 2,4, then 0 with dp=0 only while an=1011, digit 3 blank; shows " 0.42".
- Change digit_data 16'h0123 -> 16'h0456 while an=1101 -> remaining digits of current frame still show 1/blank; next frame_start shows 6,5,4.
- Assert reset_n mid-frame for 1 cycle -> an=1111, seg=1111111 same edge without a clock; after release first digit reappears 4 cycles later.
- digit_data=16'h00AB, flag=0 -> digits 0,1 blank (A–F) though an cycles normally; digits 2,3 blank by leading-zero rule.
